muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and
// restoring shift-subtract divide on magnitudes, followed by a sign fixup.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              ReadReq,
    output logic              Busy,
    output logic              Done,
    output logic              Stall,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic              r_is_div;
    logic              r_neg_a;
    logic              r_neg_b;
    logic              r_bzero;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_wh;
    logic [DATA_W-1:0] r_wl;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_issue;
    logic              w_sgn_op;
    logic [DATA_W-1:0] w_mag_a;
    logic [DATA_W-1:0] w_mag_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_sub;
    logic [2*DATA_W-1:0] w_result;

    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] f_neg2(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? (~v + {{(2*DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign w_issue  = Start && (r_state == IDLE) && (Op <= 3'd3);
    assign w_sgn_op = ~Op[0];
    assign w_mag_a  = f_neg(A, w_sgn_op & A[DATA_W-1]);
    assign w_mag_b  = f_neg(B, w_sgn_op & B[DATA_W-1]);

    // Multiply step adds the multiplicand when the low bit is set; divide step
    // shifts one dividend bit into the remainder and subtracts if it fits.
    assign w_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_d} : {(DATA_W+1){1'b0}});
    assign w_shift = {r_wh, r_wl[DATA_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_d});
    assign w_sub   = w_shift[DATA_W-1:0] - r_d;

    always_comb begin
        w_result = {r_wh, r_wl};
        if (!r_is_div) begin
            w_result = f_neg2({r_wh, r_wl}, r_neg_a ^ r_neg_b);
        end else if (r_bzero) begin
            w_result = {r_a, {DATA_W{1'b1}}};
        end else begin
            w_result = {f_neg(r_wh, r_neg_a), f_neg(r_wl, r_neg_a ^ r_neg_b)};
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_is_div <= Op[1];
            r_neg_a  <= w_sgn_op & A[DATA_W-1];
            r_neg_b  <= w_sgn_op & B[DATA_W-1];
            r_bzero  <= (B == '0);
            r_a      <= A;
            r_d      <= w_mag_b;
            r_wh     <= '0;
            r_wl     <= w_mag_a;
        end else if (r_state == RUN) begin
            if (r_is_div) begin
                r_wh <= w_ge ? w_sub : w_shift[DATA_W-1:0];
                r_wl <= {r_wl[DATA_W-2:0], w_ge};
            end else begin
                r_wh <= w_sum[DATA_W:1];
                r_wl <= {w_sum[0], r_wl[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else if (Start && Op == 3'd4) begin
                        r_hi <= A;
                    end else if (Start && Op == 3'd5) begin
                        r_lo <= A;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= FIX;
                end
                FIX: begin
                    r_state <= IDLE;
                    r_hi    <= w_result[2*DATA_W-1:DATA_W];
                    r_lo    <= w_result[DATA_W-1:0];
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy  = (r_state != IDLE);
    assign Done  = (r_state == FIX);
    assign Stall = ReadReq & (Busy | (Start & (Op <= 3'd3)));
    assign Hi    = r_hi;
    assign Lo    = r_lo;

endmodule
